// File: rtl/cond_flag_unit_pkg.sv
// Shared constants and types for the condition/flag unit.
package cond_flag_unit_pkg;

   // Flag bit positions within the flag register.
   localparam int FLG_Z  = 0;
   localparam int FLG_N  = 1;
   localparam int FLG_C  = 2;
   localparam int FLG_V  = 3;
   localparam int FLG_GT = 4;
   localparam int FLG_LT = 5;

   // Result of decoding one condition select.
   typedef struct packed {
      logic raw;
      logic err;
   } cond_dec_t;

   // The all-ones select encodes "always true".
   function automatic int sel_always_code(input int sel_w);
      return (1 << sel_w) - 1;
   endfunction

endpackage

// File: rtl/cond_flag_unit_reg.sv
// Flag register with per-bit masked write and set-only sticky bits.
// Exposes both the stored value and the value it takes at the next edge.
module cond_flag_reg
   import cond_flag_unit_pkg::*;
#(
   parameter int                NFLAGS      = 6,
   parameter logic [NFLAGS-1:0] STICKY_MASK = '0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [NFLAGS-1:0] flags_in,
   input  logic [NFLAGS-1:0] flags_mask,
   input  logic              flags_we,
   input  logic              sticky_clr,
   output logic [NFLAGS-1:0] q,
   output logic [NFLAGS-1:0] next
);

   logic [NFLAGS-1:0] base;

   // Next value: sticky clear is applied first so a same-cycle write of 1 wins.
   always_comb begin
      base = sticky_clr ? (q & ~STICKY_MASK) : q;
      next = base;
      if (flags_we) begin
         for (int i = 0; i < NFLAGS; i++) begin
            if (flags_mask[i])
               next[i] = STICKY_MASK[i] ? (base[i] | flags_in[i]) : flags_in[i];
         end
      end
   end

   // Flag storage.
   always_ff @(posedge clk) begin
      if (rst) q <= '0;
      else     q <= next;
   end

endmodule

// File: rtl/cond_flag_unit.sv
// Registered branch-condition unit: flag register plus select/invert decode
// with a one-cycle result, valid strobe and illegal-select strobe.
module cond_flag_unit
   import cond_flag_unit_pkg::*;
#(
   parameter int                NFLAGS      = 6,
   parameter int                SEL_W       = 3,
   parameter logic [NFLAGS-1:0] STICKY_MASK = '0,
   parameter bit                BYPASS      = 1'b1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [NFLAGS-1:0] flags_in,
   input  logic [NFLAGS-1:0] flags_mask,
   input  logic              flags_we,
   input  logic              sticky_clr,
   input  logic              eval_req,
   input  logic [SEL_W-1:0]  cond_sel,
   input  logic              cond_inv,
   output logic [NFLAGS-1:0] flags_q,
   output logic              cond_out,
   output logic              cond_valid,
   output logic              sel_err
);

   localparam logic [SEL_W-1:0] SEL_ALWAYS = SEL_W'(sel_always_code(SEL_W));

   logic [NFLAGS-1:0] flags_next;
   logic [NFLAGS-1:0] f;
   cond_dec_t         dec;

   cond_flag_reg #(
      .NFLAGS      (NFLAGS),
      .STICKY_MASK (STICKY_MASK)
   ) u_reg (
      .clk        (clk),
      .rst        (rst),
      .flags_in   (flags_in),
      .flags_mask (flags_mask),
      .flags_we   (flags_we),
      .sticky_clr (sticky_clr),
      .q          (flags_q),
      .next       (flags_next)
   );

   // Bypass only forwards an actual write; a lone sticky_clr is seen next cycle.
   assign f = (BYPASS && flags_we) ? flags_next : flags_q;

   // Decode select: existing flag, "always", or illegal (raw 0 + error).
   always_comb begin
      dec.raw = 1'b0;
      dec.err = 1'b1;
      if (cond_sel == SEL_ALWAYS) begin
         dec.raw = 1'b1;
         dec.err = 1'b0;
      end else begin
         for (int i = 0; i < NFLAGS; i++) begin
            if (cond_sel == SEL_W'(i)) begin
               dec.raw = f[i];
               dec.err = 1'b0;
            end
         end
      end
   end

   // Result registers: strobes track eval_req, cond_out holds between evals.
   always_ff @(posedge clk) begin
      if (rst) begin
         cond_out   <= 1'b0;
         cond_valid <= 1'b0;
         sel_err    <= 1'b0;
      end else begin
         cond_valid <= eval_req;
         sel_err    <= eval_req & dec.err;
         if (eval_req) cond_out <= dec.raw ^ cond_inv;
      end
   end

endmodule

// File: tb/tb_cond_flag_unit.sv
// Directed bench for cond_flag_unit: default, no-bypass and sticky-V variants
// share one stimulus stream; expectations are hand-computed constants.
module tb_cond_flag_unit;
   import cond_flag_unit_pkg::*;

   logic       clk = 1'b0;
   logic       rst;
   logic [5:0] flags_in, flags_mask;
   logic       flags_we, sticky_clr, eval_req, cond_inv;
   logic [2:0] cond_sel;

   logic [5:0] q_a, q_b, q_s;
   logic       out_a, out_b, out_s;
   logic       vld_a, vld_b, vld_s;
   logic       err_a, err_b, err_s;

   int nvec = 0;
   int nerr = 0;

   always #5 clk = ~clk;

   cond_flag_unit u_dut (
      .clk(clk), .rst(rst), .flags_in(flags_in), .flags_mask(flags_mask),
      .flags_we(flags_we), .sticky_clr(sticky_clr), .eval_req(eval_req),
      .cond_sel(cond_sel), .cond_inv(cond_inv), .flags_q(q_a),
      .cond_out(out_a), .cond_valid(vld_a), .sel_err(err_a));

   cond_flag_unit #(.BYPASS(1'b0)) u_nobyp (
      .clk(clk), .rst(rst), .flags_in(flags_in), .flags_mask(flags_mask),
      .flags_we(flags_we), .sticky_clr(sticky_clr), .eval_req(eval_req),
      .cond_sel(cond_sel), .cond_inv(cond_inv), .flags_q(q_b),
      .cond_out(out_b), .cond_valid(vld_b), .sel_err(err_b));

   cond_flag_unit #(.STICKY_MASK(6'b001000)) u_stk (
      .clk(clk), .rst(rst), .flags_in(flags_in), .flags_mask(flags_mask),
      .flags_we(flags_we), .sticky_clr(sticky_clr), .eval_req(eval_req),
      .cond_sel(cond_sel), .cond_inv(cond_inv), .flags_q(q_s),
      .cond_out(out_s), .cond_valid(vld_s), .sel_err(err_s));

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      nvec++;
      if (got !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Advance one edge; inputs are driven and outputs sampled 1ns after it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic eval(input logic [2:0] sel, input logic inv);
      eval_req = 1'b1;
      cond_sel = sel;
      cond_inv = inv;
   endtask

   task automatic wr(input logic [5:0] mask, input logic [5:0] val);
      flags_we   = 1'b1;
      flags_mask = mask;
      flags_in   = val;
   endtask

   task automatic idle();
      flags_we   = 1'b0;
      sticky_clr = 1'b0;
      eval_req   = 1'b0;
      cond_inv   = 1'b0;
   endtask

   logic [5:0] t1_exp;

   initial begin
      rst = 1'b1; flags_in = '0; flags_mask = '0; cond_sel = '0;
      idle();
      tick(); tick();
      chk("rst_flags", 32'(q_a), 32'h0);
      chk("rst_out",   32'(out_a), 32'h0);
      chk("rst_vld",   32'(vld_a), 32'h0);
      chk("rst_err",   32'(err_a), 32'h0);
      rst = 1'b0;

      // T1: load 010010, then walk selects 0..5
      wr(6'b111111, 6'b010010);
      tick();
      idle();
      chk("t1_flags", 32'(q_a), 32'h12);
      t1_exp = 6'b010010;
      for (int s = 0; s < 6; s++) begin
         eval(3'(s), 1'b0);
         tick();
         chk($sformatf("t1_out_sel%0d", s), 32'(out_a), 32'(t1_exp[s]));
         chk($sformatf("t1_vld_sel%0d", s), 32'(vld_a), 32'h1);
      end
      eval(3'(FLG_N), 1'b0);
      tick();
      chk("t1_out_n", 32'(out_a), 32'h1);
      idle();
      tick();
      chk("hold_vld", 32'(vld_a), 32'h0);
      chk("hold_out", 32'(out_a), 32'h1);

      // T2: always, inverted always, illegal
      eval(3'd7, 1'b0); tick();
      chk("t2_always", 32'(out_a), 32'h1);
      chk("t2_always_err", 32'(err_a), 32'h0);
      eval(3'd7, 1'b1); tick();
      chk("t2_always_inv", 32'(out_a), 32'h0);
      eval(3'd6, 1'b0); tick();
      chk("t2_ill_out", 32'(out_a), 32'h0);
      chk("t2_ill_err", 32'(err_a), 32'h1);
      eval(3'd6, 1'b1); tick();
      chk("t2_ill_inv_out", 32'(out_a), 32'h1);
      chk("t2_ill_inv_err", 32'(err_a), 32'h1);
      idle(); tick();
      chk("t2_err_drop", 32'(err_a), 32'h0);
      chk("t2_vld_drop", 32'(vld_a), 32'h0);

      // T3: partial mask write
      wr(6'b000011, 6'b111101); tick(); idle();
      chk("t3_flags", 32'(q_a), 32'h11);

      // T4: clear Z, then same-cycle write Z=1 with eval of Z
      wr(6'b000001, 6'b000000); tick();
      chk("t4_z_clr", 32'(q_a), 32'h10);
      wr(6'b000001, 6'b000001);
      eval(3'(FLG_Z), 1'b0);
      tick();
      idle();
      chk("t4_byp_out", 32'(out_a), 32'h1);
      chk("t4_nobyp_out", 32'(out_b), 32'h0);
      chk("t4_nobyp_flags", 32'(q_b), 32'h11);
      eval(3'(FLG_Z), 1'b0); tick(); idle();
      chk("t4_nobyp_reeval", 32'(out_b), 32'h1);

      // T5: sticky V
      wr(6'b001000, 6'b001000); tick(); idle();
      chk("t5_set", 32'(q_s), 32'h19);
      wr(6'b001000, 6'b000000);
      eval(3'(FLG_V), 1'b0);
      tick(); idle();
      chk("t5_stk_hold", 32'(q_s), 32'h19);
      chk("t5_plain_clr", 32'(q_a), 32'h11);
      chk("t5_stk_byp_out", 32'(out_s), 32'h1);
      chk("t5_plain_byp_out", 32'(out_a), 32'h0);
      sticky_clr = 1'b1; tick(); idle();
      chk("t5_sclr", 32'(q_s), 32'h11);
      chk("t5_sclr_plain", 32'(q_a), 32'h11);
      sticky_clr = 1'b1;
      wr(6'b001000, 6'b001000); tick(); idle();
      chk("t5_sclr_wr", 32'(q_s), 32'h19);

      // T6: reset in the middle of a back-to-back eval stream
      eval(3'(FLG_Z), 1'b0); tick();
      chk("t6_pre_vld", 32'(vld_a), 32'h1);
      chk("t6_pre_out", 32'(out_a), 32'h1);
      tick();
      rst = 1'b1; tick();
      chk("t6_rst_flags", 32'(q_a), 32'h0);
      chk("t6_rst_vld", 32'(vld_a), 32'h0);
      chk("t6_rst_out", 32'(out_a), 32'h0);
      rst = 1'b0;
      eval(3'd7, 1'b0); tick();
      chk("t6_resume_vld", 32'(vld_a), 32'h1);
      chk("t6_resume_out", 32'(out_a), 32'h1);
      eval(3'(FLG_GT), 1'b0); tick();
      chk("t6_resume_gt", 32'(out_a), 32'h0);
      idle(); tick();

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
